// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining a synchronous TX FIFO: pops one byte per frame and
// shifts it out as start, LSB-first data, optional parity, stop.
module uart_tx_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit;

  logic                  bit_last;
  logic                  fetch_ok;
  logic [DIV_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  assign bit_last  = (baud_cnt == BAUD_LAST);
  assign fetch_ok  = tx_en && !fifo_empty;
  assign cnt_inc   = baud_cnt + DIV_WIDTH'(1);
  assign shreg_nxt = shreg >> 1;

  // Outputs are registered together with the state so they always decode the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_bit    <= 1'b0;
      txd        <= 1'b1;
      fifo_r_en  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_r_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (fetch_ok) begin
            state     <= FETCH;
            fifo_r_en <= 1'b1;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          // Read data is valid now, one cycle after the pop strobe.
          state    <= START;
          shreg    <= fifo_r_data;
          par_en_q <= parity_en;
          par_bit  <= (^fifo_r_data) ^ parity_odd;
          baud_cnt <= '0;
          bit_idx  <= '0;
          txd      <= 1'b0;
        end
        START: begin
          if (bit_last) begin
            baud_cnt <= '0;
            state    <= DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= cnt_inc;
          end
        end
        DATA: begin
          if (bit_last) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              if (par_en_q) begin
                state <= PARITY;
                txd   <= par_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg_nxt;
              txd     <= shreg_nxt[0];
            end
          end else begin
            baud_cnt <= cnt_inc;
          end
        end
        PARITY: begin
          if (bit_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= cnt_inc;
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (bit_last) begin
            baud_cnt <= '0;
            // Chain straight into the next pop when more data is queued.
            if (fetch_ok) begin
              state     <= FETCH;
              fifo_r_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt   <= cnt_inc;
            frame_done <= (cnt_inc == BAUD_LAST);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench for uart_tx_fifo_reader: directed bytes go into a FIFO model and
// an expected-frame queue; a line monitor decodes txd and checks each frame.
module tb_uart_tx_fifo_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned B  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    logic       b2b;
    logic       abort;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic          parity_en;
  logic          parity_odd;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_r_data = '0;
  logic          txd;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];

  uart_tx_fifo_reader #(.DATA_WIDTH(DW), .BAUD_DIV(B), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .parity_en(parity_en), .parity_odd(parity_odd),
    .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_r_data(fifo_r_data),
    .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic pb,
                              input logic b2b, input logic ab);
    exp_t e;
    e.data = d; e.par_en = pe; e.par_bit = pb; e.b2b = b2b; e.abort = ab;
    return e;
  endfunction

  // FIFO read-side model: pop on strobe, data valid the following cycle.
  logic prev_ren = 1'b0;
  always @(negedge clk) begin
    if (fifo_r_en === 1'b1) begin
      check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
      check("pop_single_cycle", 32'(prev_ren), 0);
      if (fifo_q.size() != 0) fifo_r_data = fifo_q.pop_front();
      pops++;
    end
    prev_ren   = (fifo_r_en === 1'b1);
    fifo_empty = (fifo_q.size() == 0);
  end

  // Line monitor: decodes each frame mid-bit and compares against the queued expectation.
  bit         in_frame = 1'b0;
  int         pos, len, glitch, done_err, last_done = 0, bitn;
  exp_t       cur;
  logic [7:0] rx_data;
  logic       rx_start, rx_stop, rx_par;
  logic       prev_txd = 1'b1;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (in_frame) begin
        check("abort_expected", 32'(cur.abort), 1);
        in_frame = 1'b0;
      end
    end else begin
      if (!in_frame && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 0, 1);
          cur = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          cur = exp_q.pop_front();
        end
        if (cur.b2b) check("b2b_gap", 32'(cyc - last_done), 3);
        in_frame = 1'b1; pos = 0; glitch = 0; done_err = 0;
        rx_data = '0; rx_start = 1'b1; rx_stop = 1'b0; rx_par = 1'b0;
        len = int'(10 + 32'(cur.par_en)) * B;
      end
      if (in_frame) begin
        if ((pos % B) != 0 && txd !== prev_txd) glitch++;
        if (frame_done !== (pos == len - 1)) done_err++;
        if ((pos % B) == B / 2) begin
          bitn = pos / B;
          if (bitn == 0) rx_start = txd;
          else if (bitn <= DW) rx_data[bitn-1] = txd;
          else if (cur.par_en && bitn == DW + 1) rx_par = txd;
          else rx_stop = txd;
        end
        if (pos == len - 1) begin
          check("frame_data", 32'(rx_data), 32'(cur.data));
          if (cur.par_en) check("parity_bit", 32'(rx_par), 32'(cur.par_bit));
          check("start_bit", 32'(rx_start), 0);
          check("stop_bit", 32'(rx_stop), 1);
          check("bit_stable", 32'(glitch), 0);
          check("frame_done_timing", 32'(done_err), 0);
          check("frame_not_aborted", 32'(cur.abort), 0);
          in_frame  = 1'b0;
          last_done = cyc;
        end
        pos++;
      end
    end
    prev_txd = txd;
  end

  task automatic wait_start(input string name, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (txd === 1'b0) hit = 1'b1;
    end
    if (!hit) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) hit = 1'b1;
    end
    if (!hit) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s, p0, p1, err;
    rst = 1'b1; tx_en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;

    // Reset held with data queued and tx_en high.
    @(posedge clk); #1;
    fifo_q.push_back(8'h3C); exp_q.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({txd, busy, fifo_r_en}), 32'(3'b100));
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_fetch_after_reset", 32'({fifo_r_en, busy}), 32'(2'b11));
    wait_done("reset_frame", 60);
    @(negedge clk);
    check("idle_after_frame", 32'({busy, txd}), 32'(2'b01));

    // Single 0xA5, no parity, with exact cycle positions.
    @(posedge clk); #1;
    fifo_q.push_back(8'hA5); exp_q.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); k = cyc;
    @(negedge clk);
    check("fetch_n_plus_1", 32'(fifo_r_en), 1);
    @(negedge clk);
    check("fetch_one_pulse", 32'(fifo_r_en), 0);
    wait_start("a5_start", 20);
    check("start_n_plus_3", 32'(cyc - k), 3);
    wait_done("a5_done", 60);
    check("done_n_plus_42", 32'(cyc - k), 42);
    @(negedge clk);
    check("busy_low_n_plus_43", 32'(busy), 0);

    // Parity even then odd, with parity_odd toggled mid-frame.
    parity_en = 1'b1; parity_odd = 1'b0;
    @(posedge clk); #1;
    fifo_q.push_back(8'hA5); exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_start("even_start", 20); s = cyc;
    repeat (10) @(negedge clk);
    parity_odd = 1'b1;
    wait_done("even_done", 60);
    check("parity_frame_len", 32'(cyc - s), 43);
    @(posedge clk); #1;
    fifo_q.push_back(8'hA5); exp_q.push_back(mk(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0));
    wait_start("odd_start", 20);
    repeat (10) @(negedge clk);
    parity_odd = 1'b0;
    wait_done("odd_done", 60);
    parity_en = 1'b0;

    // Back-to-back frames.
    p0 = pops;
    @(posedge clk); #1;
    fifo_q.push_back(8'h01); exp_q.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    fifo_q.push_back(8'h80); exp_q.push_back(mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_done("b2b_first", 60);
    wait_done("b2b_second", 60);
    repeat (5) @(negedge clk);
    check("b2b_pop_count", 32'(pops - p0), 2);

    // Empty FIFO with tx_en high.
    err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_r_en !== 1'b0 || txd !== 1'b1) err++;
    end
    check("empty_no_pop", 32'(err), 0);

    // tx_en dropped during DATA with a second byte queued.
    p0 = pops;
    @(posedge clk); #1;
    fifo_q.push_back(8'h5A); exp_q.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
    fifo_q.push_back(8'hC3);
    wait_start("drop_start", 20);
    repeat (8) @(negedge clk);
    tx_en = 1'b0;
    wait_done("drop_done", 60);
    repeat (10) @(negedge clk);
    check("drop_pop_count", 32'(pops - p0), 1);
    check("drop_idle", 32'({busy, txd}), 32'(2'b01));

    // Reset during DATA bit 3 of 0xC3; 0x96 follows after release.
    @(posedge clk); #1;
    exp_q.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1));
    fifo_q.push_back(8'h96); exp_q.push_back(mk(8'h96, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    tx_en = 1'b1;
    wait_start("rst_frame_start", 20);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame_outputs", 32'({txd, busy, fifo_r_en}), 32'(3'b100));
    p1 = pops;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fetch_after_mid_reset", 32'(fifo_r_en), 1);
    wait_done("post_reset_done", 60);
    repeat (10) @(negedge clk);
    check("post_reset_pop_count", 32'(pops - p1), 1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
Serial transmitter that sits on the read side of the MCU's synchronous TX FIFO. It pops one byte at a time through the FIFO's empty/read-enable/read-data interface and shifts it out on a UART line as start, data LSB-first, optional parity and stop. It is the consumer for the byte stream that the CPU's SBUF write path pushes into the FIFO.

Parameters:
DATA_WIDTH, 8, bits per character; must match the FIFO data width.
BAUD_DIV, 434, clk cycles per UART bit; legal range 2..65535.
DIV_WIDTH, 16, width of the baud counter; must satisfy 2^DIV_WIDTH > BAUD_DIV.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous active-high reset.
tx_en  input  1  enables fetching of new frames; a frame already in progress always completes.
parity_en  input  1  adds a parity bit; sampled in LOAD and held for the whole frame.
parity_odd  input  1  1 selects odd parity, 0 selects even; sampled in LOAD.
fifo_empty  input  1  FIFO empty flag.
fifo_r_en  output  1  FIFO pop strobe; asserted for exactly one cycle per frame.
fifo_r_data  input  DATA_WIDTH  FIFO read data; valid one cycle after fifo_r_en.
txd  output  1  serial line; idles high.
busy  output  1  high from FETCH through the final STOP cycle.
frame_done  output  1  one-cycle pulse on the last cycle of STOP.

Behaviour:
- Reset: state IDLE; txd=1, fifo_r_en=0, busy=0, frame_done=0; baud counter, bit index and shift register cleared.
- Reset asserted mid-frame: next cycle txd=1, the frame is abandoned, no further pop is issued.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP. All outputs are Moore outputs, decoded from the registered state.
- IDLE: if tx_en=1 and fifo_empty=0 in cycle N, the state is FETCH in N+1. Otherwise stay in IDLE with txd=1.
- FETCH: exactly one cycle with fifo_r_en=1; next state LOAD.
- LOAD: one cycle. At its end, capture fifo_r_data into the shift register and latch parity_en and parity_odd. Compute parity = XOR of the data bits, inverted when odd. Next state START.
- START: txd=0 for BAUD_DIV cycles.
- DATA: bit i is driven for BAUD_DIV cycles, i = 0..DATA_WIDTH-1, LSB first.
- PARITY: entered only if parity_en was latched as 1; txd=parity bit for BAUD_DIV cycles.
- STOP: txd=1 for BAUD_DIV cycles; frame_done=1 on the last of them.
- Baud counter: counts 0..BAUD_DIV-1 and wraps to 0. A bit or state advances only when the count equals BAUD_DIV-1. The counter is zeroed on entry to START.
- Leaving STOP: if tx_en=1 and fifo_empty=0 in that last STOP cycle, go directly to FETCH. This gives 2 idle-high cycles (FETCH, LOAD) between frames. Otherwise go to IDLE.
- Frame length from the first START cycle: (1 + DATA_WIDTH + parity_en + 1) × BAUD_DIV cycles.
- fifo_empty is evaluated only in IDLE and in the last STOP cycle. The FIFO's empty flag lags its pointers, but that is never observed: pops are at least 10×BAUD_DIV cycles apart.
- fifo_r_en is never asserted while fifo_empty=1 is seen in the evaluating cycle. At most one pop per frame.
- tx_en falling mid-frame: the current frame finishes normally; no new FETCH.
- parity_en or parity_odd changing mid-frame has no effect until the next LOAD.

Test Plan:
- Reset defaults: hold rst=1 for 3 cycles with the FIFO non-empty and tx_en=1 -> txd=1, busy=0, fifo_r_en=0 throughout; first FETCH occurs the cycle after the first cycle with rst=0.
- Single byte, BAUD_DIV=4, no parity: FIFO holds 0xA5, tx_en=1 sampled in IDLE at cycle N -> fifo_r_en=1 only at N+1; txd=0 over N+3..N+6; then 1,0,1,0,0,1,0,1, 4 cycles each; stop=1 over N+39..N+42; frame_done=1 at N+42; busy=0 at N+43.
- Parity: 0xA5 with parity_en=1 -> even gives parity bit 0, odd gives 1; frame is 44 cycles long from START; parity_odd toggled during DATA does not change the bit.
- Back-to-back: FIFO holds 0x01, 0x80, tx_en=1 -> exactly 2 pops; 2 idle-high cycles between the first frame's STOP and the second frame's START; second frame's data bits are 0,0,0,0,0,0,0,1.
- Empty and disable: FIFO empty with tx_en=1 for 100 cycles -> no fifo_r_en, txd=1. tx_en dropped during DATA with data still queued -> current frame completes, FSM returns to IDLE, no further pop.
- Reset mid-frame: assert rst during DATA bit 3 -> txd=1 the next cycle, FSM in IDLE; after release the next queued byte is fetched with exactly one pop.
